// File: rtl/mem_stage_sized.sv
// ============================================================================
// Module   : mem_stage_sized
// Purpose  : Pipeline MEM stage with sized loads/stores, access latency and
//            sticky capture of the first faulting address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_sized #(
  parameter int WORD_LEN  = 32,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] ALU_res,
  input  logic [WORD_LEN-1:0] ST_value,
  input  logic [1:0]          mem_size,
  input  logic                load_unsigned,
  output logic [WORD_LEN-1:0] dataMem_out,
  output logic                mem_stall,
  output logic                mem_fault,
  output logic                fault_valid,
  output logic [WORD_LEN-1:0] fault_addr
);

  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_LEN-1:0] C_LO     = WORD_LEN'(BASE_ADDR);
  localparam logic [WORD_LEN-1:0] C_HI     = WORD_LEN'(BASE_ADDR + 4 * DEPTH);
  localparam logic              C_MULTI    = (LATENCY != 0);
  localparam logic [3:0]        C_CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [WORD_LEN-1:0]   r_mem [DEPTH];

  logic                  w_req, w_is_store, w_is_load;
  logic                  w_oor, w_mis, w_bad;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_lane;
  logic                  w_size_b, w_size_h;
  logic                  w_complete, w_do;
  logic [WORD_LEN-1:0]   w_word, w_load_val, w_wdata;
  logic [3:0]            w_mask;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_req      = MEM_R_EN | MEM_W_EN;
  assign w_is_store = MEM_W_EN;
  assign w_is_load  = MEM_R_EN & ~MEM_W_EN;

  assign w_idx    = IDX_W'((ALU_res - C_LO) >> 2);
  assign w_lane   = ALU_res[1:0];
  assign w_size_b = (mem_size == 2'b00);
  assign w_size_h = (mem_size == 2'b01);

  assign w_oor = (ALU_res < C_LO) || (ALU_res >= C_HI);
  assign w_mis = (w_size_h && w_lane[0]) || (!w_size_b && !w_size_h && (w_lane != 2'b00));
  assign w_bad = w_oor | w_mis;

  assign mem_fault = w_req && w_bad && (r_state == IDLE);

  // Completion: single-cycle path in IDLE, otherwise the last BUSY cycle.
  assign w_complete = C_MULTI ? ((r_state == BUSY) && (r_cnt == 4'd0)) : w_req;
  assign w_do       = w_complete && w_req && !w_bad;

  assign w_word = r_mem[w_idx];
  assign w_byte = 8'(w_word >> {w_lane, 3'b000});
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_val = w_word;
    if (w_size_b)
      w_load_val = {{(WORD_LEN-8){~load_unsigned & w_byte[7]}}, w_byte};
    else if (w_size_h)
      w_load_val = {{(WORD_LEN-16){~load_unsigned & w_half[15]}}, w_half};
  end

  assign dataMem_out = (w_do && w_is_load) ? w_load_val : '0;

  // Replicate the store data across lanes so the byte mask alone selects lanes.
  always_comb begin
    w_wdata = ST_value;
    w_mask  = 4'b1111;
    if (w_size_b) begin
      w_wdata = {4{ST_value[7:0]}};
      w_mask  = 4'b0001 << w_lane;
    end else if (w_size_h) begin
      w_wdata = {2{ST_value[15:0]}};
      w_mask  = w_lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mem_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (C_MULTI && w_req && !w_bad) begin
          mem_stall   = 1'b1;
          w_cnt_nxt   = C_CNT_INIT;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          mem_stall = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_do && w_is_store) begin
      for (int b = 0; b < 4; b++)
        if (w_mask[b])
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else if (mem_fault && !fault_valid) begin
      fault_valid <= 1'b1;
      fault_addr  <= ALU_res;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sized.sv
// ============================================================================
// Module   : tb_mem_stage_sized
// Purpose  : Directed self-checking bench for mem_stage_sized at latencies 0, 3, 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_sized;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_en = 1'b0, w_en = 1'b0, uns = 1'b0;
  logic [31:0] addr = '0, st = '0;
  logic [1:0]  size = 2'b10;

  logic [31:0] dout0, dout3, dout2, fa0, fa3, fa2;
  logic        stall0, stall3, stall2, fault0, fault3, fault2, fv0, fv3, fv2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_sized #(.WORD_LEN(32), .DEPTH(64), .BASE_ADDR(1024), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_res(addr),
    .ST_value(st), .mem_size(size), .load_unsigned(uns), .dataMem_out(dout0),
    .mem_stall(stall0), .mem_fault(fault0), .fault_valid(fv0), .fault_addr(fa0));

  mem_stage_sized #(.WORD_LEN(32), .DEPTH(64), .BASE_ADDR(1024), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_res(addr),
    .ST_value(st), .mem_size(size), .load_unsigned(uns), .dataMem_out(dout3),
    .mem_stall(stall3), .mem_fault(fault3), .fault_valid(fv3), .fault_addr(fa3));

  mem_stage_sized #(.WORD_LEN(32), .DEPTH(64), .BASE_ADDR(1024), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_res(addr),
    .ST_value(st), .mem_size(size), .load_unsigned(uns), .dataMem_out(dout2),
    .mem_stall(stall2), .mem_fault(fault2), .fault_valid(fv2), .fault_addr(fa2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s, input logic u);
    r_en = r; w_en = w; addr = a; st = d; size = s; uns = u;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({stall0, stall3, stall2} !== 3'b000) begin bad++; $display("FAIL reset_stall got=%b exp=000", {stall0, stall3, stall2}); end
    total++; if ({fault0, fault3, fault2} !== 3'b000) begin bad++; $display("FAIL reset_fault got=%b exp=000", {fault0, fault3, fault2}); end
    total++; if ({fv0, fv3, fv2} !== 3'b000) begin bad++; $display("FAIL reset_fault_valid got=%b exp=000", {fv0, fv3, fv2}); end
    total++; if (fa0 !== 32'h0) begin bad++; $display("FAIL reset_fault_addr got=%h exp=00000000", fa0); end
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=00000000", dout0); end
    // a word load right after reset returns the cleared contents
    set_req(1'b1, 1'b0, 32'd1100, 32'd0, 2'b10, 1'b0);
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL reset_mem_clear got=%h exp=00000000", dout0); end
  endtask

  task automatic test_word_l0();
    do_reset();
    set_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 2'b10, 1'b0);
    total++; if ({stall0, fault0} !== 2'b00) begin bad++; $display("FAIL l0_store_flags got=%b exp=00", {stall0, fault0}); end
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL l0_store_dout got=%h exp=00000000", dout0); end
    tick();
    set_req(1'b1, 1'b0, 32'd1024, 32'd0, 2'b10, 1'b0);
    total++; if (dout0 !== 32'hDEADBEEF) begin bad++; $display("FAIL l0_word_load got=%h exp=deadbeef", dout0); end
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL l0_no_stall got=%b exp=0", stall0); end
    set_req(1'b1, 1'b0, 32'd1024, 32'd0, 2'b11, 1'b0);
    total++; if (dout0 !== 32'hDEADBEEF) begin bad++; $display("FAIL l0_size11_load got=%h exp=deadbeef", dout0); end
    set_req(1'b1, 1'b1, 32'd1024, 32'hDEADBEEF, 2'b10, 1'b0);
    total++; if (dout0 !== 32'h0) begin bad++; $display("FAIL l0_both_en_dout got=%h exp=00000000", dout0); end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    set_req(1'b0, 1'b1, 32'd1027, 32'h12345680, 2'b00, 1'b0);
    tick();
    set_req(1'b1, 1'b0, 32'd1027, 32'd0, 2'b00, 1'b0);
    total++; if (dout0 !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_signed got=%h exp=ffffff80", dout0); end
    set_req(1'b1, 1'b0, 32'd1027, 32'd0, 2'b00, 1'b1);
    total++; if (dout0 !== 32'h00000080) begin bad++; $display("FAIL byte_unsigned got=%h exp=00000080", dout0); end
    set_req(1'b1, 1'b0, 32'd1024, 32'd0, 2'b10, 1'b0);
    total++; if (dout0 !== 32'h80000000) begin bad++; $display("FAIL byte_word_view got=%h exp=80000000", dout0); end
    set_req(1'b1, 1'b0, 32'd1026, 32'd0, 2'b01, 1'b0);
    total++; if (dout0 !== 32'hFFFF8000) begin bad++; $display("FAIL half_signed got=%h exp=ffff8000", dout0); end
    set_req(1'b0, 1'b1, 32'd1028, 32'h0000BEEF, 2'b01, 1'b0);
    tick();
    set_req(1'b1, 1'b0, 32'd1028, 32'd0, 2'b10, 1'b0);
    total++; if (dout0 !== 32'h0000BEEF) begin bad++; $display("FAIL half_store_low got=%h exp=0000beef", dout0); end
  endtask

  task automatic test_fault_sticky();
    set_req(1'b0, 1'b1, 32'd1025, 32'h00001234, 2'b01, 1'b0);
    total++; if ({fault0, stall0} !== 2'b10) begin bad++; $display("FAIL misalign_flags got=%b exp=10", {fault0, stall0}); end
    total++; if (fv0 !== 1'b0) begin bad++; $display("FAIL fault_valid_early got=%b exp=0", fv0); end
    tick();
    set_req(1'b1, 1'b0, 32'd1024, 32'd0, 2'b10, 1'b0);
    total++; if (dout0 !== 32'h80000000) begin bad++; $display("FAIL misalign_no_write got=%h exp=80000000", dout0); end
    total++; if ({fv0, fault0} !== 2'b10) begin bad++; $display("FAIL fault_valid_set got=%b exp=10", {fv0, fault0}); end
    total++; if (fa0 !== 32'd1025) begin bad++; $display("FAIL fault_addr_first got=%0d exp=1025", fa0); end
    set_req(1'b1, 1'b0, 32'd2000, 32'd0, 2'b10, 1'b0);
    total++; if ({fault0, dout0} !== {1'b1, 32'h0}) begin bad++; $display("FAIL oor_2000 got=%b/%h exp=1/00000000", fault0, dout0); end
    tick();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
    total++; if (fa0 !== 32'd1025) begin bad++; $display("FAIL fault_addr_sticky got=%0d exp=1025", fa0); end
  endtask

  task automatic test_range();
    do_reset();
    set_req(1'b1, 1'b0, 32'd1020, 32'd0, 2'b10, 1'b0);
    total++; if ({fault0, stall0, fault3, stall3} !== 4'b1010) begin bad++; $display("FAIL oor_low got=%b exp=1010", {fault0, stall0, fault3, stall3}); end
    total++; if ({dout0, dout3} !== 64'h0) begin bad++; $display("FAIL oor_low_dout got=%h exp=0", {dout0, dout3}); end
    set_req(1'b1, 1'b0, 32'd1280, 32'd0, 2'b10, 1'b0);
    total++; if ({fault0, stall0, fault3, stall3} !== 4'b1010) begin bad++; $display("FAIL oor_high got=%b exp=1010", {fault0, stall0, fault3, stall3}); end
    total++; if ({dout0, dout3} !== 64'h0) begin bad++; $display("FAIL oor_high_dout got=%h exp=0", {dout0, dout3}); end
    set_req(1'b1, 1'b0, 32'd1276, 32'd0, 2'b10, 1'b0);
    total++; if ({fault0, fault3, stall3} !== 3'b001) begin bad++; $display("FAIL last_word_in_range got=%b exp=001", {fault0, fault3, stall3}); end
  endtask

  task automatic test_latency3();
    int n;
    do_reset();
    set_req(1'b0, 1'b1, 32'd1028, 32'h12345678, 2'b10, 1'b0);
    n = 0;
    while (stall3 && n < 20) begin n++; tick(); end
    total++; if (n !== 3) begin bad++; $display("FAIL l3_store_stalls got=%0d exp=3", n); end
    tick();
    set_req(1'b1, 1'b0, 32'd1028, 32'd0, 2'b10, 1'b0);
    total++; if ({stall3, dout3} !== {1'b1, 32'h0}) begin bad++; $display("FAIL l3_load_start got=%b/%h exp=1/00000000", stall3, dout3); end
    n = 0;
    while (stall3 && n < 20) begin n++; tick(); end
    total++; if (n !== 3) begin bad++; $display("FAIL l3_load_stalls got=%0d exp=3", n); end
    total++; if (dout3 !== 32'h12345678) begin bad++; $display("FAIL l3_load_data got=%h exp=12345678", dout3); end
    tick();
    set_req(1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 2'b10, 1'b0);
    n = 0;
    while (stall3 && n < 20) begin n++; tick(); end
    total++; if (n !== 3) begin bad++; $display("FAIL l3_b2b_store_stalls got=%0d exp=3", n); end
    total++; if (dout3 !== 32'h0) begin bad++; $display("FAIL l3_store_dout got=%h exp=00000000", dout3); end
    tick();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
    total++; if ({stall3, dout3} !== {1'b0, 32'h0}) begin bad++; $display("FAIL l3_idle_after got=%b/%h exp=0/00000000", stall3, dout3); end
  endtask

  task automatic test_reset_busy();
    int n;
    do_reset();
    set_req(1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 2'b10, 1'b0);
    total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL l2_store_accept got=%b exp=1", stall2); end
    tick();
    total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL l2_first_busy got=%b exp=1", stall2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
    total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL l2_after_reset_stall got=%b exp=0", stall2); end
    tick();
    set_req(1'b1, 1'b0, 32'd1032, 32'd0, 2'b10, 1'b0);
    total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL l2_idle_accept got=%b exp=1", stall2); end
    n = 0;
    while (stall2 && n < 20) begin n++; tick(); end
    total++; if (n !== 2) begin bad++; $display("FAIL l2_load_stalls got=%0d exp=2", n); end
    total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL l2_aborted_store got=%h exp=00000000", dout2); end
    tick();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_word_l0();
    test_byte_lanes();
    test_fault_sticky();
    test_range();
    test_latency3();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
- Parametrised successor of the pipeline MEM stage, sitting between the EXE/MEM and MEM/WB pipeline registers.
- Holds an internal data memory of DEPTH words addressed by byte address.
- Adds byte, halfword and word loads and stores, sign or zero extension on loads, and a configurable access latency with a stall output to the hazard unit.
- Detects misaligned and out-of-range accesses, suppresses them, and records the first faulting address.

Parameters:
- WORD_LEN, 32, data and address width in bits (fixed to 32 for byte-lane logic).
- DEPTH, 64, number of memory words.
- BASE_ADDR, 1024, byte address of word 0.
- LATENCY, 1, access latency in cycles (0..15); 0 means single-cycle, no stall.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- ALU_res  in  WORD_LEN  byte address.
- ST_value  in  WORD_LEN  store data; the low bytes are used for sub-word stores.
- mem_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- dataMem_out  out  WORD_LEN  load result.
- mem_stall  out  1  freeze upstream stages and hold all stage inputs.
- mem_fault  out  1  current request is misaligned or out of range.
- fault_valid  out  1  sticky; set on the first fault.
- fault_addr  out  WORD_LEN  address of the first fault.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - All DEPTH words cleared to 0.
  - FSM to IDLE, counter to 0.
  - fault_valid=0, fault_addr=0.
  - Combinational outputs follow: mem_stall=0, mem_fault=0, dataMem_out=0.
- Request = MEM_R_EN | MEM_W_EN. If both are set, the request is a store and dataMem_out=0.
- Address decode:
  - index = (ALU_res - BASE_ADDR) >> 2; lane = ALU_res[1:0].
  - Out of range when ALU_res < BASE_ADDR or ALU_res >= BASE_ADDR + 4*DEPTH.
  - Misaligned when halfword has lane[0]=1, or word has lane != 0.
- Fault handling:
  - mem_fault is combinational and asserts when a request is out of range or misaligned, in IDLE state only.
  - A faulting request performs no access, does not stall, and gives dataMem_out=0.
  - On the edge where mem_fault=1 and fault_valid=0: fault_valid<=1, fault_addr<=ALU_res. Later faults do not overwrite it.
- Byte lanes (little-endian):
  - Byte store writes only lane bits [8*lane+7:8*lane] from ST_value[7:0].
  - Halfword store writes lanes lane and lane+1 from ST_value[15:0].
  - Word store writes all lanes.
  - Loads extract the same lanes and extend to WORD_LEN per load_unsigned. Word loads are never extended.
- FSM with LATENCY=0:
  - Stays in IDLE.
  - Reads are combinational from the array.
  - Stores commit at the next edge.
  - mem_stall is always 0.
- FSM with LATENCY>=1, states IDLE and BUSY:
  - IDLE with a valid, non-faulting request: mem_stall=1, cnt<=LATENCY-1, next state BUSY. No access is performed.
  - BUSY with cnt!=0: mem_stall=1, cnt<=cnt-1.
  - BUSY with cnt==0: mem_stall=0. The load result is driven combinationally on dataMem_out this cycle, and a store commits at the end of this cycle. Next state IDLE.
  - Total stall cycles per access = LATENCY; total occupancy = LATENCY+1 cycles.
  - Inputs are assumed held stable by upstream while mem_stall=1. The access uses the values present in the final BUSY cycle.
- Outside the completing cycle: dataMem_out=0 when no load is completing, and in IDLE for LATENCY>=1.
- Back-to-back accesses: the next request is seen in the IDLE cycle after BUSY completes; no extra bubble beyond that.
- Reset during BUSY: the pending access is aborted, a pending store is never written, and the FSM returns to IDLE.

Test Plan:
- LATENCY=0: word store 0xDEADBEEF @1024, then word load @1024 -> dataMem_out=0xDEADBEEF on the load cycle; mem_stall never 1.
- Byte store 0x80 @1027 over word 0, then signed byte load @1027 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @1024 -> 0x80000000.
- Halfword store @1025 -> mem_fault=1, memory unchanged, fault_valid=1, fault_addr=1025; a later fault @2000 leaves fault_addr=1025.
- LATENCY=3: word load @1028 holding 0x12345678 -> mem_stall high exactly 3 cycles, value on dataMem_out in the 4th cycle; a consecutive store afterwards stalls another 3 cycles.
- LATENCY=2: store 0xAAAA5555 @1032, with rst asserted in the first BUSY cycle -> word @1032 reads 0 after reset, mem_stall=0, FSM in IDLE.
- Load @1020 and @1024+4*DEPTH -> mem_fault=1, dataMem_out=0, no stall.
